// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Canonical addi x0,x0,0; decode substitutes it for bubbles.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, single-cycle clear and head read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [$clog2(Depth):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [Depth];

  // Pointer and occupancy next state; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PtrW'(1);
      if (pop_i)  head_d = head_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset since reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: tracks the one in-flight imem request, queues returned instructions
// for decode, stalls the PC when no room remains, and flushes on redirect.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [XLEN-1:0]         req_pc,
  input  logic [XLEN-1:0]         imem_rdata,
  input  logic                    flush,
  output logic                    stall_o,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [XLEN-1:0]         dec_pc,
  output logic [XLEN-1:0]         dec_instr,
  output logic [XLEN-1:0]         dec_pc_plus4,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] FullOcc = (CntW + 1)'(DEPTH);

  logic            inflight_v_q, inflight_v_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   occ;
  logic            accept, push, pop;
  fetch_entry_t    push_data, head;

  // Occupancy includes the in-flight slot so a returning response always has room.
  // Uses registered state only: a same-cycle pop is deliberately not credited.
  assign occ     = {1'b0, count} + {{CntW{1'b0}}, inflight_v_q};
  assign stall_o = (occ == FullOcc);

  assign accept = req_valid & ~stall_o & ~flush;
  assign push   = inflight_v_q & ~flush;
  assign pop    = dec_valid & dec_ready & ~flush;

  assign push_data = '{pc: inflight_pc_q, instr: imem_rdata, pc_plus4: inflight_pc_q + XLEN'(4)};

  // In-flight next state; the PC is only updated on accept.
  always_comb begin
    inflight_v_d  = accept;
    inflight_pc_d = inflight_pc_q;
    if (accept) inflight_pc_d = req_pc;
  end

  // In-flight request register.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .clear_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign count_o   = count;
  assign dec_valid = (count != '0);

  // Head fields are forced to zero when nothing is queued.
  always_comb begin
    dec_pc       = '0;
    dec_instr    = '0;
    dec_pc_plus4 = '0;
    if (dec_valid) begin
      dec_pc       = head.pc;
      dec_instr    = head.instr;
      dec_pc_plus4 = head.pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic [31:0]     req_pc = '0;
  logic [31:0]     imem_rdata = '0;
  logic            flush = 1'b0;
  logic            stall_o;
  logic            dec_valid;
  logic            dec_ready = 1'b0;
  logic [31:0]     dec_pc, dec_instr, dec_pc_plus4;
  logic [2:0]      count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued entries plus the one outstanding memory request.
  fetch_entry_t m_q[$];
  bit           m_infl = 1'b0;
  logic [31:0]  m_infl_pc = '0;

  always #5 clk = ~clk;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .imem_rdata   (imem_rdata),
    .flush        (flush),
    .stall_o      (stall_o),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_pc       (dec_pc),
    .dec_instr    (dec_instr),
    .dec_pc_plus4 (dec_pc_plus4),
    .count_o      (count_o)
  );

  // Memory image: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] pc, input bit fl,
                     input bit rdy, output bit acc);
    bit           m_stall;
    fetch_entry_t hd;
    @(negedge clk);
    rst        = r;
    req_valid  = rv;
    req_pc     = pc;
    flush      = fl;
    dec_ready  = rdy;
    imem_rdata = m_infl ? mem_word(m_infl_pc) : $urandom;
    #1;
    m_stall = (m_q.size() + int'(m_infl)) == DEPTH;
    hd      = (m_q.size() != 0) ? m_q[0] : '0;
    check("stall", 32'(stall_o), 32'(m_stall));
    check("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
    check("count", 32'(count_o), 32'(m_q.size()));
    check("dec_pc", dec_pc, hd.pc);
    check("dec_instr", dec_instr, hd.instr);
    check("dec_pc_plus4", dec_pc_plus4, hd.pc_plus4);
    @(posedge clk);
    acc = !r && !fl && rv && !m_stall;
    if (r) begin
      m_q.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
    end else if (fl) begin
      m_q.delete();
      m_infl = 1'b0;
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{pc: m_infl_pc, instr: mem_word(m_infl_pc),
                                  pc_plus4: m_infl_pc + 32'd4});
      if (acc) m_infl_pc = pc;
      m_infl = acc;
    end
  endtask

  initial begin
    bit          acc;
    logic [31:0] pc;
    int          rdy_pct;

    cyc(1, 0, 0, 0, 0, acc);
    cyc(1, 0, 0, 0, 0, acc);

    // Back-to-back fetch of 0,4,8 with decode ready.
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, pc, 0, 1, acc);
      if (acc) pc += 4;
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, acc);

    // Fill with decode blocked; PC holds while stalled.
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, pc, 0, 0, acc);
      if (acc) pc += 4;
    end
    #1;
    check("full_count", 32'(count_o), 32'd4);
    check("full_stall", 32'(stall_o), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, acc);

    // Flush while full with a request and pop pending, then redirect to 0x100.
    pc = 32'h40;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, pc, 0, 0, acc);
      if (acc) pc += 4;
    end
    cyc(0, 1, 32'h200, 1, 1, acc);
    cyc(0, 1, 32'h100, 0, 0, acc);
    cyc(0, 0, 0, 0, 0, acc);
    #1;
    check("redirect_pc", dec_pc, 32'h100);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, acc);

    // Flush in the cycle the response returns: nothing is pushed.
    cyc(0, 1, 32'h300, 0, 0, acc);
    cyc(0, 0, 0, 1, 0, acc);
    cyc(0, 0, 0, 0, 0, acc);
    #1;
    check("flush_drop", 32'(count_o), 32'd0);

    // PC+4 wraps at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, acc);
    cyc(0, 0, 0, 0, 0, acc);
    #1;
    check("pc4_wrap", dec_pc_plus4, 32'd0);
    cyc(0, 0, 0, 0, 1, acc);

    // Sustained streaming wraps head/tail several times.
    pc = 32'h1000;
    for (int i = 0; i < 14; i++) begin
      cyc(0, 1, pc, 0, 1, acc);
      if (acc) pc += 4;
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, acc);

    // Reset mid-stream at count 2, then resume.
    pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, pc, 0, 0, acc);
      if (acc) pc += 4;
    end
    #1;
    check("pre_rst_count", 32'(count_o), 32'd2);
    cyc(1, 1, 32'h600, 1, 1, acc);
    pc = 32'h700;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, pc, 0, 1, acc);
      if (acc) pc += 4;
    end

    // Randomized traffic with varying decode back-pressure.
    pc      = 0;
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      bit r, rv, fl, rdy;
      if (i % 100 == 0) rdy_pct = $urandom_range(10, 100);
      r   = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 24) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      if (fl) pc = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom) & 32'hFFFF_FFFC;
      cyc(r, rv, pc, fl, rdy, acc);
      if (acc) pc += 4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
